// File: rtl/multi_tone_gen.sv
// multi_tone_gen: N-channel square-wave tone generator for speaker/DAC pins.
//
// Each channel has a programmable half-period (cfg_half = half-period - 1)
// and an optional burst length in full periods (0 = continuous).
// spk_on gates every channel. Retuning a running channel is glitch-free:
// new settings are held in a shadow and take effect at the channel's
// next 1->0 output toggle.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous reset, active low
//   spk_on     global enable; 0 holds every channel idle with its output low
//   cfg_valid  config write request
//   cfg_ready  config write can be accepted (low while any shadow is pending)
//   cfg_ch     target channel; indices >= NUM_CH are accepted and dropped
//   cfg_half   half-period minus one, in clk cycles
//   cfg_burst  burst length in full periods (0 = continuous)
//   cfg_en     channel enable; 0 stops the channel immediately
//   spk_pin    square-wave outputs, one bit per channel
//   ch_busy    channel is running
//   ch_done    one-cycle pulse after a burst completes
module multi_tone_gen #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 16,
    parameter int BURST_W      = 8,
    parameter int DEFAULT_HALF = 8000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      spk_on,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH):0]   cfg_ch,
    input  logic [CNT_W-1:0]          cfg_half,
    input  logic [BURST_W-1:0]        cfg_burst,
    input  logic                      cfg_en,
    output logic [NUM_CH-1:0]         spk_pin,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic [NUM_CH-1:0]         ch_done
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             st       [NUM_CH];
    logic [CNT_W-1:0]   cnt      [NUM_CH];
    logic [CNT_W-1:0]   half     [NUM_CH];
    logic [CNT_W-1:0]   sh_half  [NUM_CH];
    logic [BURST_W-1:0] bcnt     [NUM_CH];
    logic [BURST_W-1:0] bcnt_inc [NUM_CH];
    logic [BURST_W-1:0] burst    [NUM_CH];
    logic [BURST_W-1:0] sh_burst [NUM_CH];
    logic [NUM_CH-1:0]  en;
    logic [NUM_CH-1:0]  pend;
    logic [NUM_CH-1:0]  at_top;
    logic [NUM_CH-1:0]  burst_end;
    logic [NUM_CH-1:0]  hit;
    logic               accept;

    assign cfg_ready = ~|pend;
    assign accept    = cfg_valid & cfg_ready;

    always_comb begin
        at_top    = '0;
        burst_end = '0;
        hit       = '0;
        ch_busy   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bcnt_inc[i]  = bcnt[i] + 1'b1;
            at_top[i]    = (cnt[i] == half[i]);
            burst_end[i] = (burst[i] != '0) && (bcnt_inc[i] == burst[i]);
            hit[i]       = accept && (cfg_ch == CH_W'(i));
            ch_busy[i]   = (st[i] == RUN);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en      <= '0;
            pend    <= '0;
            spk_pin <= '0;
            ch_done <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st[i]       <= IDLE;
                cnt[i]      <= '0;
                bcnt[i]     <= '0;
                half[i]     <= CNT_W'(DEFAULT_HALF);
                burst[i]    <= '0;
                sh_half[i]  <= '0;
                sh_burst[i] <= '0;
            end
        end else begin
            ch_done <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (hit[i] && !cfg_en) begin
                    st[i]      <= IDLE;
                    spk_pin[i] <= 1'b0;
                    cnt[i]     <= '0;
                    bcnt[i]    <= '0;
                    pend[i]    <= 1'b0;
                    en[i]      <= 1'b0;
                    if (st[i] == IDLE || !spk_on) begin
                        half[i]  <= cfg_half;
                        burst[i] <= cfg_burst;
                    end
                end else if (!spk_on) begin
                    st[i]      <= IDLE;
                    spk_pin[i] <= 1'b0;
                    cnt[i]     <= '0;
                    bcnt[i]    <= '0;
                    if (hit[i]) begin
                        half[i]  <= cfg_half;
                        burst[i] <= cfg_burst;
                        en[i]    <= 1'b1;
                    end else if (pend[i]) begin
                        // No toggle will come while gated; commit the shadow
                        // so cfg_ready cannot stay low indefinitely.
                        half[i]  <= sh_half[i];
                        burst[i] <= sh_burst[i];
                        pend[i]  <= 1'b0;
                    end
                end else if (st[i] == IDLE) begin
                    spk_pin[i] <= 1'b0;
                    cnt[i]     <= '0;
                    bcnt[i]    <= '0;
                    if (hit[i]) begin
                        half[i]  <= cfg_half;
                        burst[i] <= cfg_burst;
                        en[i]    <= 1'b1;
                        st[i]    <= RUN;
                    end else if (en[i]) begin
                        st[i] <= RUN;
                    end
                end else if (at_top[i]) begin
                    cnt[i]     <= '0;
                    spk_pin[i] <= ~spk_pin[i];
                    if (spk_pin[i]) begin
                        if (burst_end[i])
                            ch_done[i] <= 1'b1;
                        // A write landing exactly on the falling toggle is
                        // committed directly instead of waiting a full period.
                        if (pend[i] || hit[i]) begin
                            half[i]  <= pend[i] ? sh_half[i]  : cfg_half;
                            burst[i] <= pend[i] ? sh_burst[i] : cfg_burst;
                            pend[i]  <= 1'b0;
                            bcnt[i]  <= '0;
                        end else if (burst_end[i]) begin
                            st[i]   <= IDLE;
                            en[i]   <= 1'b0;
                            bcnt[i] <= '0;
                        end else if (burst[i] != '0) begin
                            bcnt[i] <= bcnt_inc[i];
                        end
                    end else if (hit[i]) begin
                        sh_half[i]  <= cfg_half;
                        sh_burst[i] <= cfg_burst;
                        pend[i]     <= 1'b1;
                    end
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                    if (hit[i]) begin
                        sh_half[i]  <= cfg_half;
                        sh_burst[i] <= cfg_burst;
                        pend[i]     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_tone_gen.sv
// tb_multi_tone_gen: directed bench for multi_tone_gen (2 channels).
// Expected output transitions {edge index, bit, value} are queued up front;
// a monitor compares every observed transition of
// {cfg_ready, ch_done, ch_busy, spk_pin} against the queue head.
module tb_multi_tone_gen;

    logic       clk;
    logic       resetn;
    logic       spk_on;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [15:0] cfg_half;
    logic [7:0] cfg_burst;
    logic       cfg_en;
    logic [1:0] spk_pin;
    logic [1:0] ch_busy;
    logic [1:0] ch_done;

    // bit 0 pin0, 1 pin1, 2 busy0, 3 busy1, 4 done0, 5 done1, 6 ready
    logic [6:0] vec;
    assign vec = {cfg_ready, ch_done, ch_busy, spk_pin};

    typedef struct {
        int   cyc;
        int   b;
        logic v;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    logic mon_en = 1'b0;

    multi_tone_gen #(
        .NUM_CH(2),
        .CNT_W(16),
        .BURST_W(8),
        .DEFAULT_HALF(8000)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .spk_on(spk_on),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_half(cfg_half),
        .cfg_burst(cfg_burst),
        .cfg_en(cfg_en),
        .spk_pin(spk_pin),
        .ch_busy(ch_busy),
        .ch_done(ch_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got time %0t required < 100000", $time);
        $fatal(1);
    end

    function automatic void push(int c, int b, logic v);
        ev_t e;
        int  idx;
        e.cyc = c;
        e.b   = b;
        e.v   = v;
        idx   = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > c || (q[i].cyc == c && q[i].b > b)) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Monitor: every transition must match the next queued expectation.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        ev_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = vec;
            if (mon_en) begin
                for (int b = 0; b < 7; b++) begin
                    if (cur[b] != prev[b]) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: got bit %0d val %0d at cyc %0d, required no event",
                                     b, cur[b], cyc);
                        end else begin
                            e = q.pop_front();
                            if (e.cyc != cyc || e.b != b || e.v != cur[b]) begin
                                errors++;
                                $display("FAIL event: got bit %0d val %0d at cyc %0d, required bit %0d val %0d at cyc %0d",
                                         b, cur[b], cyc, e.b, e.v, e.cyc);
                            end
                        end
                    end
                end
            end
            prev = cur;
        end
    end

    // Called at posedge+1; returns at posedge e +1.
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The write is accepted on edge e.
    task automatic cfg_write(input int e, input int ch, input int h, input int bl, input logic en);
        goto(e - 1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_half  = 16'(h);
        cfg_burst = 8'(bl);
        cfg_en    = en;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    int base, a, g, c, e, p, r;

    initial begin
        resetn    = 1'b0;
        spk_on    = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_half  = '0;
        cfg_burst = '0;
        cfg_en    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'(vec), 7'b1000000);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        base = cyc;
        a = base + 3;
        g = a + 47;
        c = g + 20;
        e = g + 37;
        p = g + 45;
        r = p + 20;

        // ch0 continuous half=3: busy at accept, first rise 4 edges later
        push(a, 2, 1'b1);
        for (int k = 0; k < 3; k++) push(a + 4 + 8 * k, 0, 1'b1);
        for (int k = 0; k < 3; k++) push(a + 8 + 8 * k, 0, 1'b0);
        // retune to half=1 mid-high: ready low until the falling toggle at a+24
        push(a + 21, 6, 1'b0);
        push(a + 24, 6, 1'b1);
        for (int k = 0; k < 6; k++) push(a + 26 + 4 * k, 0, 1'b1);
        for (int k = 0; k < 5; k++) push(a + 28 + 4 * k, 0, 1'b0);
        // gate off at g (pin high since a+46), back on at g+10
        push(g, 0, 1'b0);
        push(g, 2, 1'b0);
        push(g + 10, 2, 1'b1);
        for (int k = 0; k < 7; k++) push(g + 12 + 4 * k, 0, 1'b1);
        for (int k = 0; k < 6; k++) push(g + 14 + 4 * k, 0, 1'b0);
        // ch1 burst half=1 x2
        push(c, 3, 1'b1);
        push(c + 2, 1, 1'b1);
        push(c + 4, 1, 1'b0);
        push(c + 6, 1, 1'b1);
        push(c + 8, 1, 1'b0);
        push(c + 8, 3, 1'b0);
        push(c + 8, 5, 1'b1);
        push(c + 9, 5, 1'b0);
        // disable ch0 while high
        push(e, 0, 1'b0);
        push(e, 2, 1'b0);
        // ch1 burst=1 with a pending retune landing on the final toggle
        push(p, 3, 1'b1);
        push(p + 2, 1, 1'b1);
        push(p + 3, 6, 1'b0);
        push(p + 4, 1, 1'b0);
        push(p + 4, 5, 1'b1);
        push(p + 4, 6, 1'b1);
        push(p + 5, 5, 1'b0);
        push(p + 7, 1, 1'b1);
        push(p + 10, 1, 1'b0);
        push(p + 10, 3, 1'b0);
        push(p + 10, 5, 1'b1);
        push(p + 11, 5, 1'b0);
        // ch0 restart before the async reset
        push(r, 2, 1'b1);
        push(r + 4, 0, 1'b1);

        cfg_write(a, 0, 3, 0, 1'b1);
        cfg_write(a + 21, 0, 1, 0, 1'b1);
        goto(g - 1);
        spk_on = 1'b0;
        goto(g + 9);
        spk_on = 1'b1;
        cfg_write(c, 1, 1, 2, 1'b1);
        cfg_write(g + 30, 2, 0, 0, 1'b0);
        cfg_write(e, 0, 0, 0, 1'b0);
        cfg_write(p, 1, 1, 1, 1'b1);
        cfg_write(p + 3, 1, 2, 1, 1'b1);
        cfg_write(r, 0, 3, 0, 1'b1);

        goto(r + 5);
        #2;
        check("pin_high_before_reset", int'(spk_pin), 1);
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        check("async_reset", int'(vec), 7'b1000000);
        @(posedge clk);
        #1;
        check("reset_hold", int'(vec), 7'b1000000);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        goto(cyc + 10);
        check("idle_after_reset", int'(vec), 7'b1000000);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
